rsa_keygen_scheduler: RTL and testbench

- Round-robin scheduler that shares one RSA key-generation engine (WIDTH-bit keygen core, next/done pulse interface) among NUM_REQ requesters.
- Arbitrates requests and issues a single-cycle start pulse to the engine. Waits for the engine's done, then returns a one-cycle acknowledge to the winning requester.
- Keeps a completed-key counter and, optionally, a watchdog that aborts a hung engine run.
- Sits between the key-management front end and the keygen engine.

---
 rtl/rsa_keygen_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 23 ++
 rtl/rsa_keygen_scheduler.sv | 115 +++++++++++
 tb/tb_rsa_keygen_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rsa_keygen_pkg.sv
// Shared types, defaults and the rotating-priority search for the RSA keygen scheduler.
package rsa_keygen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DefTimeoutCycles = 1048576;
  localparam int unsigned MaxReq = 16;

  // Returns {valid, id}: first set bit of req at or above ptr, wrapping at num.
  function automatic logic [4:0] rr_search(input logic [15:0] req, input logic [3:0] ptr,
                                           input int unsigned num);
    logic [4:0] res;
    int idx;
    res = '0;
    // Walk offsets downward so the smallest offset is the last one written.
    for (int i = int'(MaxReq) - 1; i >= 0; i--) begin
      if (i < int'(num)) begin
        idx = (int'(ptr) + i) % int'(num);
        if (req[idx[3:0]]) res = {1'b1, idx[3:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the scheduler.
module rr_arbiter
  import rsa_keygen_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               en,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id
);

  logic [4:0] pick;

  always_comb begin
    pick        = rr_search(16'(req), 4'(rr_ptr), NUM_REQ);
    grant_valid = en & pick[4];
    grant_id    = ID_W'(pick[3:0]);
  end

endmodule

// File: rtl/rsa_keygen_scheduler.sv
// Shares one RSA keygen engine among NUM_REQ requesters with round-robin grants.
// Optional watchdog abort enabled by defining RSA_KEYGEN_SCHED_WDOG_EN.
module rsa_keygen_scheduler
  import rsa_keygen_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = $clog2(NUM_REQ),
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned TO_W           = 21
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               ack_err,
  output logic [ID_W-1:0]    owner,
  output logic               busy,
  output logic               eng_next,
  input  logic               eng_done,
  output logic [CNT_W-1:0]   key_count
);

  localparam logic [ID_W-1:0] LastId = ID_W'(NUM_REQ - 1);

  state_e          state;
  logic [ID_W-1:0] rr_ptr;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .en         (en),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

`ifdef RSA_KEYGEN_SCHED_WDOG_EN
  localparam logic [TO_W-1:0] WdogLast = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wdog;
  logic            ack_err_q;
  assign ack_err = ack_err_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^TO_W'(TIMEOUT_CYCLES);
  assign ack_err = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= StIdle;
      rr_ptr    <= '0;
      ack       <= '0;
      owner     <= '0;
      busy      <= 1'b0;
      eng_next  <= 1'b0;
      key_count <= '0;
`ifdef RSA_KEYGEN_SCHED_WDOG_EN
      wdog      <= '0;
      ack_err_q <= 1'b0;
`endif
    end else begin
      eng_next <= 1'b0;
      ack      <= '0;
`ifdef RSA_KEYGEN_SCHED_WDOG_EN
      ack_err_q <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          if (grant_valid) begin
            owner    <= grant_id;
            rr_ptr   <= (grant_id == LastId) ? '0 : grant_id + 1'b1;
            eng_next <= 1'b1;
            busy     <= 1'b1;
            state    <= StIssue;
          end
        end
        StIssue: begin
          // Any done seen alongside the start pulse belongs to a previous run.
          state <= StWait;
`ifdef RSA_KEYGEN_SCHED_WDOG_EN
          wdog  <= '0;
`endif
        end
        StWait: begin
          if (eng_done) begin
            state     <= StResp;
            ack       <= NUM_REQ'(1) << owner;
            key_count <= key_count + 1'b1;
          end
`ifdef RSA_KEYGEN_SCHED_WDOG_EN
          else if (wdog == WdogLast) begin
            state     <= StResp;
            ack       <= NUM_REQ'(1) << owner;
            ack_err_q <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        StResp: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_scheduler.sv
// Directed bench for rsa_keygen_scheduler: per-cycle vector table plus job sequences.
module tb_rsa_keygen_scheduler;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  ack;
  logic        ack_err;
  logic [1:0]  owner;
  logic        busy;
  logic        eng_next;
  logic        eng_done = 1'b0;
  logic [31:0] key_count;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  rsa_keygen_scheduler #(
    .NUM_REQ       (4),
    .ID_W          (2),
    .CNT_W         (32),
    .TIMEOUT_CYCLES(16),
    .TO_W          (5)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .en       (en),
    .req      (req),
    .ack      (ack),
    .ack_err  (ack_err),
    .owner    (owner),
    .busy     (busy),
    .eng_next (eng_next),
    .eng_done (eng_done),
    .key_count(key_count)
  );

  typedef struct {
    logic [3:0]  req;
    logic        en;
    logic        done;
    logic [3:0]  e_ack;
    logic        e_next;
    logic        e_busy;
    logic [1:0]  e_owner;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [3:0] r, input logic e, input logic d,
                              input logic [3:0] ea, input logic en_x, input logic eb,
                              input logic [1:0] eo, input logic [31:0] ec);
    vecs.push_back('{r, e, d, ea, en_x, eb, eo, ec});
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_ack_err"}, 32'(ack_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_eng_next"}, 32'(eng_next), 0);
    chk({tag, "_owner"}, 32'(owner), 0);
    chk({tag, "_key_count"}, key_count, 0);
  endtask

  // Waits for the start pulse, checks the winner, finishes the job 4 cycles later.
  task automatic do_job(input int exp_own, input int exp_cnt);
    int n;
    n = 0;
    while (eng_next !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("grant_seen", 32'(eng_next), 1);
    chk("grant_owner", 32'(owner), 32'(exp_own));
    @(negedge aclk);
    chk("next_single", 32'(eng_next), 0);
    repeat (3) @(negedge aclk);
    eng_done = 1'b1;
    @(negedge aclk);
    eng_done = 1'b0;
    chk("job_ack", 32'(ack), 32'(1) << exp_own);
    chk("job_ack_err", 32'(ack_err), 0);
    chk("job_count", key_count, 32'(exp_cnt));
  endtask

  initial begin
    int n;

    // Single job from requester 0; stale done in IDLE and ISSUE; req dropped mid-WAIT.
    add(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0);
    add(4'b0001, 1, 1, 4'b0000, 1, 1, 0, 0);
    add(4'b0001, 1, 1, 4'b0000, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) add(4'b0001, 1, 0, 4'b0000, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) add(4'b0000, 1, 0, 4'b0000, 0, 1, 0, 0);
    add(4'b0000, 1, 1, 4'b0001, 0, 1, 0, 1);
    add(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1);
    add(4'b0000, 1, 1, 4'b0000, 0, 0, 0, 1);
    add(4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1);

    repeat (2) @(negedge aclk);
    chk_idle_zero("reset");
    areset = 1'b0;

    foreach (vecs[i]) begin
      req      = vecs[i].req;
      en       = vecs[i].en;
      eng_done = vecs[i].done;
      @(negedge aclk);
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_next", i), 32'(eng_next), 32'(vecs[i].e_next));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].e_owner));
      chk($sformatf("vec%0d_count", i), key_count, vecs[i].e_cnt);
    end
    eng_done = 1'b0;

    // Fresh reset, then all four requesting: rotation 0,1,2,3,0.
    areset = 1'b1;
    @(negedge aclk);
    chk_idle_zero("reset2");
    areset = 1'b0;
    req = 4'b1111;
    en = 1'b1;
    do_job(0, 1);
    do_job(1, 2);
    do_job(2, 3);
    do_job(3, 4);
    do_job(0, 5);

    // Grants disabled: requester 1 waits, then wins the cycle after en rises.
    en = 1'b0;
    req = 4'b0010;
    n = 0;
    repeat (50) begin
      @(negedge aclk);
      if (eng_next === 1'b1) n++;
    end
    chk("en_low_no_next", 32'(n), 0);
    chk("en_low_idle", 32'(busy), 0);
    en = 1'b1;
    @(negedge aclk);
    chk("en_rise_next", 32'(eng_next), 1);
    chk("en_rise_owner", 32'(owner), 1);

    // Reset in WAIT: job dropped, pointer back to 0 so requester 1 beats 3.
    req = 4'b1010;
    repeat (3) @(negedge aclk);
    chk("wait_busy", 32'(busy), 1);
    areset = 1'b1;
    #1;
    chk_idle_zero("reset_wait");
    @(negedge aclk);
    areset = 1'b0;
    do_job(1, 1);
    // Requester 1 still held after its ack, so 3 goes next.
    do_job(3, 2);

`ifdef RSA_KEYGEN_SCHED_WDOG_EN
    // Engine never answers: watchdog aborts 17 cycles after the start pulse.
    n = 0;
    while (eng_next !== 1'b1 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("wd_grant_seen", 32'(eng_next), 1);
    chk("wd_owner", 32'(owner), 1);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (ack === 4'b0000 && n < 40);
    chk("wd_latency", 32'(n), 17);
    chk("wd_ack", 32'(ack), 32'(4'b0010));
    chk("wd_ack_err", 32'(ack_err), 1);
    chk("wd_count", key_count, 2);
    do_job(3, 3);
`endif

    req = 4'b0000;
    repeat (3) @(negedge aclk);
    chk("final_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
